// File: rtl/mm_tile_sequencer.sv
// Tile sequencer for one matmul job: load both fetchers, feed, supervise the stream, drain, flag result.
// Optional feature macro: MM_SEQ_ABORT_EN adds an abort input that returns any active job to IDLE.

module mm_tile_sequencer #(
    parameter int ARRAY_LEN    = 8,
    parameter int DRAIN_CYCLES = 2 * ARRAY_LEN,
    parameter int TILE_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef MM_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic [TILE_W-1:0] num_tiles,
    output logic              busy,
    output logic              done,
    output logic              load_req_a,
    output logic              load_req_b,
    input  logic              load_done_a,
    input  logic              load_done_b,
    output logic              feed,
    input  logic              valid_a,
    input  logic              valid_b,
    output logic              acc_clear,
    output logic              result_valid,
    output logic [TILE_W-1:0] tile_idx,
    output logic              err
);

    localparam int CNT_MAX = (ARRAY_LEN > DRAIN_CYCLES) ? ARRAY_LEN : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(ARRAY_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_STREAM,
        S_DRAIN,
        S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
    logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
    logic              got_a_q, got_a_d;
    logic              got_b_q, got_b_d;
    logic              err_q, err_d;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tile_idx_d  = tile_idx_q;
        num_tiles_d = num_tiles_q;
        got_a_d     = got_a_q;
        got_b_d     = got_b_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (num_tiles != '0) begin
                        num_tiles_d = num_tiles;
                        tile_idx_d  = '0;
                        state_d     = S_LOAD;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_LOAD: begin
                // A done pulse in this cycle counts toward leaving LOAD immediately.
                got_a_d = got_a_q | load_done_a;
                got_b_d = got_b_q | load_done_b;
                if (got_a_d && got_b_d) begin
                    got_a_d = 1'b0;
                    got_b_d = 1'b0;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                cnt_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (!valid_a || !valid_b) begin
                    err_d = 1'b1;
                end
                if (cnt_q == STREAM_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d = '0;
                    if (tile_idx_q == num_tiles_q - TILE_W'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        tile_idx_d = tile_idx_q + TILE_W'(1);
                        state_d    = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MM_SEQ_ABORT_EN
        // Abort overrides any transition above; err keeps its pre-abort value.
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            tile_idx_d = '0;
            got_a_d    = 1'b0;
            got_b_d    = 1'b0;
            err_d      = err_q;
        end
`endif
    end

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tile_idx_q  <= '0;
            num_tiles_q <= '0;
            got_a_q     <= 1'b0;
            got_b_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_idx_q  <= tile_idx_d;
            num_tiles_q <= num_tiles_d;
            got_a_q     <= got_a_d;
            got_b_q     <= got_b_d;
            err_q       <= err_d;
        end
    end

    // Outputs decode registered state only, so an async reset clears them in the same cycle.
    assign busy         = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done         = (state_q == S_FIN);
    assign load_req_a   = (state_q == S_LOAD) && !got_a_q;
    assign load_req_b   = (state_q == S_LOAD) && !got_b_q;
    assign feed         = (state_q == S_FEED);
    assign acc_clear    = (state_q == S_FEED);
    assign result_valid = (state_q == S_DRAIN) && (cnt_q == DRAIN_LAST);
    assign tile_idx     = tile_idx_q;
    assign err          = err_q;

endmodule
